pool_seq_ctrl: RTL

- Sequences a multi-channel max-pool pass through the 2x2/stride-2 pooling datapath.
- Per channel: pulses the pool FIFO clear (cal_start), streams one 24x24 activation map from the feature-map RAM, and collects the 144 pooled words into the output RAM at per-channel offsets.
- Sits between the conv/activation result buffer and the FC-layer input buffer; started by the layer scheduler, reports busy/done.

---
 rtl/pool_seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: sequences a multi-channel 2x2/stride-2 max-pool pass.
// Each channel gets a pool FIFO clear, then a full MAP_DIM x MAP_DIM read
// stream, and its pooled results are written at a per-channel output offset.
// Optional drain watchdog: define POOL_SEQ_CTRL_WDOG_EN.
module pool_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int MAP_DIM = 24,
  parameter int CH_W    = 4,
  parameter int IN_AW   = 13,
  parameter int OUT_AW  = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   num_ch,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fm_rd_en,
  output logic [IN_AW-1:0]  fm_rd_addr,
  input  logic [DATA_W-1:0] fm_rd_data,
  output logic [DATA_W-1:0] act_data,
  output logic              act_data_vld,
  output logic              cal_start,
  input  logic [DATA_W-1:0] pool_data,
  input  logic              pool_data_vld,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);

  localparam int PIX_N = MAP_DIM * MAP_DIM;
  localparam int RES_N = (MAP_DIM / 2) * (MAP_DIM / 2);
  localparam int PIX_W = $clog2(PIX_N + 1);
  localparam int RES_W = $clog2(RES_N + 1);

  localparam logic [IN_AW-1:0]  IN_STEP  = IN_AW'(PIX_N);
  localparam logic [OUT_AW-1:0] OUT_STEP = OUT_AW'(RES_N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [CH_W-1:0]   num_ch_r, ch_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [RES_W-1:0]  res_cnt;
  // Channel base addresses are accumulated instead of multiplied; the
  // result equals ch_cnt*step truncated to the address width.
  logic [IN_AW-1:0]  in_base;
  logic [OUT_AW-1:0] out_base;
  logic              act_vld_r;
  logic              capture, last_pix, last_res, last_ch, wd_expire;

  assign capture  = pool_data_vld && (state == S_FEED || state == S_DRAIN);
  assign last_pix = (pix_cnt == PIX_W'(PIX_N - 1));
  // Leave DRAIN as soon as the final result is captured; its write then
  // issues in NEXT, so done lands one cycle after the last write.
  assign last_res = (res_cnt == RES_W'(RES_N)) ||
                    (capture && res_cnt == RES_W'(RES_N - 1));
  assign last_ch  = (ch_cnt == num_ch_r - 1'b1);

`ifdef POOL_SEQ_CTRL_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_r;

  assign wd_expire = (state == S_DRAIN) && !last_res &&
                     (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err = err_r;

  // Drain watchdog counter and sticky error flag
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wd_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      wd_cnt <= (state == S_DRAIN) ? wd_cnt + 1'b1 : '0;
      if (state == S_IDLE && start) err_r <= 1'b0;
      else if (wd_expire)           err_r <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_ch == '0) ? S_DONE : S_CLR;
      S_CLR:   state_nxt = S_FEED;
      S_FEED:  if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (last_res)       state_nxt = S_NEXT;
        else if (wd_expire) state_nxt = S_DONE;
      end
      S_NEXT:  state_nxt = last_ch ? S_DONE : S_CLR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, channel/pixel/result counters and channel bases
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= S_IDLE;
      num_ch_r <= '0;
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      res_cnt  <= '0;
      in_base  <= '0;
      out_base <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          num_ch_r <= num_ch;
          ch_cnt   <= '0;
          in_base  <= '0;
          out_base <= '0;
        end
        S_CLR: begin
          pix_cnt <= '0;
          res_cnt <= '0;
        end
        S_FEED: pix_cnt <= pix_cnt + 1'b1;
        S_NEXT: if (!last_ch) begin
          ch_cnt   <= ch_cnt + 1'b1;
          in_base  <= in_base + IN_STEP;
          out_base <= out_base + OUT_STEP;
        end
        default: ;
      endcase
      if (capture) res_cnt <= res_cnt + 1'b1;
    end
  end

  // Read-stream valid delay and pooled-result write register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      act_vld_r   <= 1'b0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      act_vld_r <= fm_rd_en;
      out_wr_en <= capture;
      if (capture) begin
        out_wr_addr <= out_base + OUT_AW'(res_cnt);
        out_wr_data <= pool_data;
      end
    end
  end

  assign busy         = (state == S_CLR) || (state == S_FEED) ||
                        (state == S_DRAIN) || (state == S_NEXT);
  assign done         = (state == S_DONE);
  assign cal_start    = (state == S_CLR);
  assign fm_rd_en     = (state == S_FEED);
  assign fm_rd_addr   = fm_rd_en ? in_base + IN_AW'(pix_cnt) : '0;
  assign act_data_vld = act_vld_r;
  assign act_data     = act_vld_r ? fm_rd_data : '0;

endmodule
